// File: rtl/od_sensor_scheduler.sv
// od_sensor_scheduler
// Shares one object-detection timer between NUM_SENS ultrasonic channels.
// A round-robin arbiter picks a pending sensor, the timer is loaded with
// the one-way time (time_taken/2), the FSM waits for Object_detected or
// time_out (bounded by a watchdog), then the result is offered to the CAN
// update path and folded into a per-sensor detection map.
// Optional build macro: OD_FRONT_PRIORITY_EN -- sensor 0 always wins when
// it requests, and serving it leaves the round-robin pointer untouched.
//
// Result handshake: a frame transfers on every rising edge where
// tx_valid && tx_ready. tx_valid rises only in REPORT, and while it is high
// tx_id and tx_detected do not change. Once raised, tx_valid stays high
// until the transfer; it never drops without one (except on reset).

module od_sensor_scheduler #(
   parameter int NUM_SENS = 4,
   parameter int TW       = 23,
   parameter int IDW      = 2,
   parameter int WD_CYC   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SENS-1:0]    req,
   input  logic [NUM_SENS*TW-1:0] time_taken,
   output logic [NUM_SENS-1:0]    grant,
   output logic                   tmr_start,
   output logic [TW-1:0]          tmr_value,
   input  logic                   time_out,
   input  logic                   Object_detected,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [IDW-1:0]         tx_id,
   output logic                   tx_detected,
   output logic [NUM_SENS-1:0]    obj_map,
   output logic                   busy,
   output logic                   wd_err,
   output logic [1:0]             fsm_state
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_START  = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   localparam int WDW = $clog2(WD_CYC + 1);

   logic [1:0]     state;
   logic [IDW-1:0] sel;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win;
   logic           found;
   logic           result;
   logic [WDW-1:0] wd_cnt;

   // Arbiter: first requesting sensor at or after ptr, wrapping around.
   always_comb begin
      int j;
      logic [IDW-1:0] jj;
      win   = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int i = 0; i < NUM_SENS; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_SENS) j = j - NUM_SENS;
         jj = IDW'(j);
         if (!found && req[jj]) begin
            found = 1'b1;
            win   = jj;
         end
      end
`ifdef OD_FRONT_PRIORITY_EN
      if (req[0]) win = '0;
`endif
   end

   // Main FSM: capture, start timer, wait with watchdog, report result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         sel       <= '0;
         ptr       <= '0;
         tmr_value <= '0;
         result    <= 1'b0;
         wd_cnt    <= '0;
         wd_err    <= 1'b0;
         obj_map   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req) begin
                  sel       <= win;
                  tmr_value <= time_taken[int'(win)*TW +: TW] >> 1;
                  state     <= S_START;
               end
            end
            S_START: begin
               wd_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               // Detection takes precedence over a coincident time_out.
               if (Object_detected) begin
                  result <= 1'b1;
                  state  <= S_REPORT;
               end else if (time_out) begin
                  result <= 1'b0;
                  state  <= S_REPORT;
               end else if (wd_cnt == WDW'(WD_CYC - 1)) begin
                  result <= 1'b0;
                  wd_err <= 1'b1;
                  state  <= S_REPORT;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            S_REPORT: begin
               if (tx_ready) begin
                  obj_map[sel] <= result;
`ifdef OD_FRONT_PRIORITY_EN
                  if (sel != '0)
                     ptr <= (sel == IDW'(NUM_SENS - 1)) ? '0 : sel + 1'b1;
`else
                  ptr <= (sel == IDW'(NUM_SENS - 1)) ? '0 : sel + 1'b1;
`endif
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Output decode: pulses and frame fields derive from the current state.
   always_comb begin
      grant = '0;
      if (state == S_START) grant[sel] = 1'b1;
      tmr_start   = (state == S_START);
      tx_valid    = (state == S_REPORT);
      tx_id       = (state == S_REPORT) ? sel : '0;
      tx_detected = (state == S_REPORT) ? result : 1'b0;
      busy        = (state != S_IDLE);
      fsm_state   = state;
   end

endmodule

// File: tb/tb_od_sensor_scheduler.sv
// Directed bench for od_sensor_scheduler: a table of per-cycle vectors for
// the basic detection and round-robin sequences, plus hand-written
// sequences for reset, watchdog, back-pressure and mid-operation reset.
// Inputs change and outputs are checked on the falling clock edge.

module tb_od_sensor_scheduler;

  localparam int NUM_SENS = 4;
  localparam int TW       = 23;
  localparam int IDW      = 2;
  localparam int WD_CYC   = 16;

  logic                   clk;
  logic                   rst;
  logic [NUM_SENS-1:0]    req;
  logic [NUM_SENS*TW-1:0] time_taken;
  logic [NUM_SENS-1:0]    grant;
  logic                   tmr_start;
  logic [TW-1:0]          tmr_value;
  logic                   time_out;
  logic                   Object_detected;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [IDW-1:0]         tx_id;
  logic                   tx_detected;
  logic [NUM_SENS-1:0]    obj_map;
  logic                   busy;
  logic                   wd_err;
  logic [1:0]             fsm_state;

  od_sensor_scheduler #(
    .NUM_SENS(NUM_SENS), .TW(TW), .IDW(IDW), .WD_CYC(WD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .time_taken(time_taken),
    .grant(grant), .tmr_start(tmr_start), .tmr_value(tmr_value),
    .time_out(time_out), .Object_detected(Object_detected),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_id(tx_id),
    .tx_detected(tx_detected), .obj_map(obj_map), .busy(busy),
    .wd_err(wd_err), .fsm_state(fsm_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          do_rst;
    logic [3:0]    req;
    logic          to;
    logic          od;
    logic          rdy;
    logic [3:0]    e_grant;
    logic          e_tstart;
    logic [TW-1:0] e_tval;
    logic          e_valid;
    logic [1:0]    e_id;
    logic          e_det;
    logic [3:0]    e_map;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_err = 0;

  // Hand-computed tmr_value per sensor: 7>>1, 1>>1, 10>>1, 0x7FFFFF>>1.
  logic [TW-1:0] tv_exp [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] r, input logic t, input logic o, input logic y);
    req = r;
    time_out = t;
    Object_detected = o;
    tx_ready = y;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(4'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic add_vec(input logic dr, input logic [3:0] r, input logic t, input logic o,
                         input logic y, input logic [3:0] eg, input logic ets,
                         input logic [TW-1:0] etv, input logic ev, input logic [1:0] eid,
                         input logic edet, input logic [3:0] emap, input logic eb);
    vec_t v;
    v.do_rst = dr; v.req = r; v.to = t; v.od = o; v.rdy = y;
    v.e_grant = eg; v.e_tstart = ets; v.e_tval = etv; v.e_valid = ev;
    v.e_id = eid; v.e_det = edet; v.e_map = emap; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  initial begin
    int g;
    int g6;
    int cyc;
    tv_exp[0] = 23'd3;
    tv_exp[1] = 23'd0;
    tv_exp[2] = 23'd5;
    tv_exp[3] = 23'h3FFFFF;

    // ---- Reset with random inputs ----
    rst = 1'b0;
    time_taken = '0;
    set_in(4'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req = 4'($urandom_range(0, 15));
      time_out = 1'($urandom_range(0, 1));
      Object_detected = 1'($urandom_range(0, 1));
      tx_ready = 1'($urandom_range(0, 1));
      time_taken = {23'($urandom), 23'($urandom), 23'($urandom), 23'($urandom)};
      #1;
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_tstart", 32'(tmr_start), 32'h0);
      check("rst_valid", 32'(tx_valid), 32'h0);
      check("rst_map", 32'(obj_map), 32'h0);
      check("rst_wd", 32'(wd_err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_tval", 32'(tmr_value), 32'h0);
    end
    @(negedge clk);
    set_in(4'b0, 1'b0, 1'b0, 1'b0);
    time_taken = {23'h7FFFFF, 23'd10, 23'd1, 23'd7};
    rst = 1'b1;
    step();
    check("idle_after_rst", 32'(busy), 32'h0);

    // ---- Table: single detection on sensor 2 (3rd WAIT cycle) ----
    add_vec(0, 4'b0100, 0, 0, 1, 4'b0100, 1, tv_exp[2], 0, 0, 0, 4'b0000, 1);
    add_vec(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 0,         0, 0, 0, 4'b0000, 1);
    add_vec(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 0,         0, 0, 0, 4'b0000, 1);
    add_vec(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 0,         0, 0, 0, 4'b0000, 1);
    add_vec(0, 4'b0000, 0, 1, 1, 4'b0000, 0, 0,         1, 2, 1, 4'b0000, 1);
    add_vec(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 0,         0, 0, 0, 4'b0100, 0);

    // ---- Table: all requesting, time_out 2 cycles after each tmr_start ----
    for (int m = 0; m < 5; m++) begin
`ifdef OD_FRONT_PRIORITY_EN
      g = 0;
`else
      g = m % 4;
`endif
      add_vec((m == 0), 4'b1111, 0, 0, 1, 4'(1 << g), 1, tv_exp[g], 0, 0, 0, 4'b0000, 1);
      add_vec(0, 4'b1111, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1);
      add_vec(0, 4'b1111, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1);
      add_vec(0, 4'b1111, 1, 0, 1, 4'b0000, 0, 0, 1, 2'(g), 0, 4'b0000, 1);
      add_vec(0, 4'b1111, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0);
    end

    // ---- Table: detection and time_out together, sensor 1 (tmr_value floors to 0) ----
    add_vec(0, 4'b0010, 0, 0, 1, 4'b0010, 1, tv_exp[1], 0, 0, 0, 4'b0000, 1);
    add_vec(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 0,         0, 0, 0, 4'b0000, 1);
    add_vec(0, 4'b0000, 1, 1, 1, 4'b0000, 0, 0,         1, 1, 1, 4'b0000, 1);
    add_vec(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 0,         0, 0, 0, 4'b0010, 0);

    foreach (vecs[k]) begin
      if (vecs[k].do_rst) do_reset();
      set_in(vecs[k].req, vecs[k].to, vecs[k].od, vecs[k].rdy);
      step();
      check($sformatf("v%0d_grant", k), 32'(grant), 32'(vecs[k].e_grant));
      check($sformatf("v%0d_tstart", k), 32'(tmr_start), 32'(vecs[k].e_tstart));
      if (vecs[k].e_tstart)
        check($sformatf("v%0d_tval", k), 32'(tmr_value), 32'(vecs[k].e_tval));
      check($sformatf("v%0d_valid", k), 32'(tx_valid), 32'(vecs[k].e_valid));
      if (vecs[k].e_valid) begin
        check($sformatf("v%0d_id", k), 32'(tx_id), 32'(vecs[k].e_id));
        check($sformatf("v%0d_det", k), 32'(tx_detected), 32'(vecs[k].e_det));
      end
      check($sformatf("v%0d_map", k), 32'(obj_map), 32'(vecs[k].e_map));
      check($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].e_busy));
      check($sformatf("v%0d_wd", k), 32'(wd_err), 32'h0);
    end

    // ---- Watchdog on sensor 3 ----
    set_in(4'b1000, 1'b0, 1'b0, 1'b1);
    step();
    check("wd_grant", 32'(grant), 32'h8);
    check("wd_tval", 32'(tmr_value), 32'(tv_exp[3]));
    set_in(4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    check("wd_err_early", 32'(wd_err), 32'h0);
    cyc = 1;
    while (!tx_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("wd_report_seen", 32'(tx_valid), 32'h1);
    check("wd_id", 32'(tx_id), 32'h3);
    check("wd_det", 32'(tx_detected), 32'h0);
    check("wd_err_set", 32'(wd_err), 32'h1);
    step();
    check("wd_map", 32'(obj_map), 32'h2);
    check("wd_idle", 32'(busy), 32'h0);

    // Normal detection on sensor 2 afterwards: wd_err must stay set.
    set_in(4'b0100, 1'b0, 1'b0, 1'b1);
    step();
    check("post_wd_grant", 32'(grant), 32'h4);
    set_in(4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    set_in(4'b0000, 1'b0, 1'b1, 1'b1);
    step();
    check("post_wd_det", 32'(tx_detected), 32'h1);
    set_in(4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    check("post_wd_map", 32'(obj_map), 32'h6);
    check("wd_err_sticky", 32'(wd_err), 32'h1);

    // ---- Back-pressure in REPORT, then reset during WAIT ----
`ifdef OD_FRONT_PRIORITY_EN
    g6 = 0;
`else
    g6 = 3;
`endif
    set_in(4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    check("stall_grant", 32'(grant), 32'(1 << g6));
    step();
    set_in(4'b1111, 1'b1, 1'b0, 1'b0);
    step();
    set_in(4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_valid", i), 32'(tx_valid), 32'h1);
      check($sformatf("stall%0d_id", i), 32'(tx_id), 32'(g6));
      check($sformatf("stall%0d_det", i), 32'(tx_detected), 32'h0);
      check($sformatf("stall%0d_grant", i), 32'(grant), 32'h0);
      check($sformatf("stall%0d_tstart", i), 32'(tmr_start), 32'h0);
      step();
    end
    tx_ready = 1'b1;
    step();
    check("stall_release_map", 32'(obj_map), 32'h6);
    check("stall_release_idle", 32'(busy), 32'h0);
    step();
    check("restart_tstart", 32'(tmr_start), 32'h1);
    step();
    check("in_wait_busy", 32'(busy), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_valid", 32'(tx_valid), 32'h0);
    check("abort_map", 32'(obj_map), 32'h0);
    check("abort_wd", 32'(wd_err), 32'h0);
    step();
    check("abort_hold_valid", 32'(tx_valid), 32'h0);
    check("abort_hold_grant", 32'(grant), 32'h0);
    rst = 1'b1;
    set_in(4'b0000, 1'b0, 1'b0, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/od_sensor_scheduler.md
Name: od_sensor_scheduler

Overview:
Shares one object-detection timer (OD_time) between NUM_SENS ultrasonic sensor channels. Round-robin arbitration picks one pending measurement, loads the timer with the one-way time (time_taken/2), then waits for Object_detected or time_out. The result goes to the CAN update path through a valid/ready handshake, and a per-sensor detection map is maintained.

Parameters:
NUM_SENS, 4, number of sensor requesters (2..8)
TW, 23, width of time_taken / timer load value
IDW, 2, sensor id width, clog2(NUM_SENS)
WD_CYC, 16, watchdog limit: max cycles in WAIT before forced no-detect

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  NUM_SENS  sensor i has a measurement pending; held until grant[i]
time_taken  in  NUM_SENS*TW  packed, sensor i at [i*TW +: TW], round-trip time
grant  out  NUM_SENS  one-hot, 1-cycle pulse: request consumed
tmr_start  out  1  1-cycle pulse: load timer with tmr_value
tmr_value  out  TW  captured time_taken>>1 of the granted sensor
time_out  in  1  timer expired, no object
Object_detected  in  1  timer reports object in range
tx_valid  out  1  result frame valid for CAN update
tx_ready  in  1  CAN side accepts frame
tx_id  out  IDW  sensor id of the result
tx_detected  out  1  1 = object detected
obj_map  out  NUM_SENS  latest accepted result per sensor
busy  out  1  FSM not in IDLE
wd_err  out  1  sticky: watchdog fired at least once

Behaviour:
- Reset (rst=0, async): FSM=IDLE, rr pointer=0, all outputs 0, including obj_map, wd_err and tmr_value.
- FSM states: IDLE, START, WAIT, REPORT.
- IDLE:
  - If |req, the winner is the first set bit scanning from rr pointer upward with wrap.
  - At that edge: register sel=winner and tmr_value=time_taken[sel]>>1 (floor), then go to START.
- START (exactly 1 cycle):
  - grant[sel]=1, tmr_start=1.
  - time_out and Object_detected are ignored this cycle.
  - Go to WAIT and clear the watchdog counter.
- WAIT:
  - Object_detected=1 -> result=1, go to REPORT.
  - Else time_out=1 -> result=0, go to REPORT.
  - Both in the same cycle: detection wins, result=1.
  - Counter reaches WD_CYC with neither -> result=0, set wd_err, go to REPORT.
- REPORT:
  - tx_valid=1; tx_id=sel and tx_detected=result, held stable while tx_ready=0.
  - On tx_valid&&tx_ready: obj_map[sel]=result, rr pointer=(sel+1) mod NUM_SENS, go to IDLE.
- Latency: req sampled at edge k -> grant/tmr_start high during cycle k+1 -> earliest tx_valid in cycle k+3. The minimum per-measurement period is 4 cycles with tx_ready held high.
- time_taken=0 or 1: tmr_value=0, normal sequence still runs.
- req changes while busy are ignored until IDLE. A req dropped before its grant is lost, with no error.
- Only one measurement is in flight at a time. No new grant while tx_valid is stalled.
- busy=1 in START, WAIT and REPORT.
- Reset mid-operation: immediate abort, no tx_valid, obj_map cleared.

Optional Feature:
OD_FRONT_PRIORITY_EN
- Defined: sensor 0 (front bumper) has strict priority. If req[0]=1 in IDLE it wins regardless of rr pointer. The rr pointer is not updated when sensor 0 is served.
- Undefined: pure round-robin for all sensors.

Test Plan:
1. Reset: hold rst=0 with random inputs -> grant=0, tmr_start=0, tx_valid=0, obj_map=0, wd_err=0, busy=0. Release rst -> IDLE.
2. req=4'b0100, time_taken[2]=10; Object_detected=1 in 3rd WAIT cycle; tx_ready=1 -> START: grant=0100, tmr_value=5. Then tx_valid=1, tx_id=2, tx_detected=1 for 1 cycle; obj_map=0100.
3. req=4'b1111 held, time_out=1 two cycles after each tmr_start, tx_ready=1 -> grant order 0001,0010,0100,1000,0001; tx_detected=0 each time. With OD_FRONT_PRIORITY_EN: every grant=0001.
4. Object_detected=1 and time_out=1 in the same WAIT cycle, sensor 1 -> tx_id=1, tx_detected=1.
5. Sensor 3 granted, neither timer input asserted for WD_CYC=16 cycles -> tx_detected=0, wd_err=1, which stays 1 over subsequent normal measurements until rst=0.
6. tx_ready=0 for 5 cycles in REPORT with req=1111 -> tx_valid/tx_id/tx_detected stable, no grant pulse. Then assert rst=0 during the next WAIT -> busy=0, no tx_valid.
